// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared state type and memory write codes for the data memory arbiter
package data_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_IO} state_t;
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;
  localparam logic [1:0] MW_RSVD = 2'b01;
  function automatic logic [1:0] issue_code(input logic [1:0] we);
    return (we == MW_RSVD) ? MW_NONE : we;
  endfunction
endpackage

// File: rtl/data_mem_arb_pick.sv
// data_mem_arb_pick: two-port winner select; bit0 = CPU, bit1 = IO, prio 1 favours IO on a tie
module data_mem_arb_pick (
  input  logic [1:0] elig,
  input  logic       prio,
  output logic [1:0] win
);
  always_comb win = (elig == 2'b11) ? (prio ? 2'b10 : 2'b01) : elig;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: CPU/IO data memory arbiter; define DMARB_ROUND_ROBIN_EN for round-robin ties, else CPU wins
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic [1:0]        io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t     state;
  logic [1:0] elig;
  logic [1:0] win;
  logic       prio;
  assign cpu_gnt   = (state == ACC_CPU);
  assign io_gnt    = (state == ACC_IO);
  assign cpu_rdata = mem_rdata;
  assign io_rdata  = mem_rdata;
  assign busy      = (state != IDLE) | cpu_rvalid | io_rvalid;
  assign elig      = {io_req & ~io_gnt, cpu_req & ~cpu_gnt};
`ifdef DMARB_ROUND_ROBIN_EN
  logic ptr;
  assign prio = ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (|win) ptr <= win[0];
`else
  assign prio = 1'b0;
`endif
  data_mem_arb_pick u_pick (
    .elig(elig),
    .prio(prio),
    .win (win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      mem_we     <= MW_NONE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_rvalid <= (state == ACC_CPU) && (mem_we == MW_NONE);
      io_rvalid  <= (state == ACC_IO) && (mem_we == MW_NONE);
      state      <= win[0] ? ACC_CPU : win[1] ? ACC_IO : IDLE;
      mem_we     <= win[0] ? issue_code(cpu_we) : win[1] ? issue_code(io_we) : MW_NONE;
      if (|win) begin
        mem_addr  <= win[0] ? cpu_addr : io_addr;
        mem_wdata <= win[0] ? cpu_wdata : io_wdata;
      end
    end
  end
endmodule
